led_seq_ctrl: RTL and testbench

LED pattern sequencer for the 3-LED board output. It takes one active-low pushbutton, debounces it, and uses each press to step a mode FSM through four display patterns: binary count, chase, blink and PWM breathe. It owns the LED pins and paces each pattern from a parameterised step-tick prescaler driven by the board clock.

---
 rtl/led_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: debounced pushbutton steps COUNT/CHASE/BLINK/BREATHE on 3 LEDs.
// Latency: led is registered one cycle behind pattern state; press reaches mode 2+DEB_CYCLES+1 cycles after btn_n falls.
// Backpressure: none; free-running pattern engine, button presses are never queued or dropped once accepted.
module led_seq_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_DIV   = 2_500_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_n,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  // Divisors below 2 leave no room for a distinct tick cycle or a real debounce window.
  if (TICK_DIV < 2 || DEB_CYCLES < 2 || CLK_HZ < 1) begin : g_bad_param
    $error("led_seq_ctrl: TICK_DIV and DEB_CYCLES must be >= 2, CLK_HZ positive");
  end

  typedef enum logic [1:0] {
    M_COUNT   = 2'd0,
    M_CHASE   = 2'd1,
    M_BLINK   = 2'd2,
    M_BREATHE = 2'd3
  } mode_e;

  logic          sync1, sync2;
  logic          deb_state, deb_prev;
  logic [DW-1:0] deb_cnt;
  logic          press;
  mode_e         mode_q, mode_nxt;
  logic [PW-1:0] presc;
  logic [2:0]    step;
  logic          phase;
  logic [7:0]    duty;
  logic          dir_up;
  logic [7:0]    pwm_cnt;
  logic [2:0]    led_nxt;

  // Two-flop synchroniser; idles at 1 so reset looks like a released button.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_state <= 1'b1;
      deb_prev  <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      deb_prev <= deb_state;
      if (sync2 == deb_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) begin
        deb_state <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Only the press edge (1->0) matters; releases are ignored.
  assign press = deb_prev & ~deb_state;
  assign tick  = (presc == PRESC_MAX);
  assign mode  = mode_q;

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mode_q <= M_COUNT;
    else       mode_q <= mode_nxt;
  end

  // Mode FSM next state: advance one mode per press.
  always_comb begin
    mode_nxt = mode_q;
    if (press) begin
      case (mode_q)
        M_COUNT:   mode_nxt = M_CHASE;
        M_CHASE:   mode_nxt = M_BLINK;
        M_BLINK:   mode_nxt = M_BREATHE;
        default:   mode_nxt = M_COUNT;
      endcase
    end
  end

  // Step prescaler; a mode change restarts the tick period from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              presc <= '0;
    else if (press || tick) presc <= '0;
    else                    presc <= presc + 1'b1;
  end

  // Pattern state: cleared on mode change (press beats a coincident tick), advanced per tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step   <= '0;
      phase  <= 1'b0;
      duty   <= '0;
      dir_up <= 1'b1;
    end else if (press) begin
      step   <= '0;
      phase  <= 1'b0;
      duty   <= '0;
      dir_up <= 1'b1;
    end else if (tick) begin
      case (mode_q)
        M_COUNT: step  <= step + 3'd1;
        M_CHASE: step  <= (step >= 3'd2) ? 3'd0 : step + 3'd1;
        M_BLINK: phase <= ~phase;
        default: begin
          if (dir_up) begin
            if (duty == 8'd240) begin
              duty   <= 8'd224;
              dir_up <= 1'b0;
            end else begin
              duty <= duty + 8'd16;
            end
          end else begin
            if (duty == 8'd0) begin
              duty   <= 8'd16;
              dir_up <= 1'b1;
            end else begin
              duty <= duty - 8'd16;
            end
          end
        end
      endcase
    end
  end

  // PWM frame counter runs regardless of mode; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 8'd1;
  end

  // Map current pattern state to an LED image.
  always_comb begin
    led_nxt = 3'b000;
    case (mode_q)
      M_COUNT: led_nxt = step;
      M_CHASE: led_nxt = 3'b001 << step[1:0];
      M_BLINK: led_nxt = {3{phase}};
      default: led_nxt = {3{pwm_cnt < duty}};
    endcase
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) led <= 3'b000;
    else       led <= led_nxt;
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with TICK_DIV=4, DEB_CYCLES=8.
// Checks every cycle against a pattern model computed from tick counts and a sliding button window.
// Inputs change 1 ns after posedge; outputs sampled at that same point.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_n;
  logic [2:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  led_seq_ctrl #(.CLK_HZ(50_000_000), .TICK_DIV(4), .DEB_CYCLES(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .btn_n (btn_n),
    .led   (led),
    .mode  (mode),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  // Reference model state: edges since last mode anchor, edges since reset,
  // accepted button level, pending press, and last 10 btn_n samples (index = edges ago).
  int   m_mode, m_j, m_g;
  logic [2:0] m_led;
  bit   m_deb, m_pend;
  logic hist [10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern after k ticks in a mode; breathe duty is a 30-tick triangle 0..240..0.
  function automatic logic [2:0] pat(input int md, input int k, input int pwm);
    int m, d;
    case (md)
      0: return 3'(k % 8);
      1: return 3'(1 << (k % 3));
      2: return ((k % 2) == 1) ? 3'b111 : 3'b000;
      default: begin
        m = k % 30;
        d = (m <= 15) ? 16 * m : 16 * (30 - m);
        return (pwm < d) ? 3'b111 : 3'b000;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_j = 0; m_g = 0; m_led = 3'b000;
    m_deb = 1'b1; m_pend = 1'b0;
    for (int i = 0; i < 10; i++) hist[i] = 1'b1;
  endtask

  // Advance model over the coming edge, clock once, then compare.
  task automatic step();
    logic [2:0] lnext;
    bit press_now, all0, all1;
    lnext = pat(m_mode, m_j / 4, m_g % 256);
    press_now = m_pend;
    for (int i = 9; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn_n;
    all0 = 1'b1; all1 = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      if (hist[i]) all0 = 1'b0;
      else         all1 = 1'b0;
    end
    m_pend = 1'b0;
    if (m_deb && all0) begin
      m_deb = 1'b0;
      m_pend = 1'b1;
    end else if (!m_deb && all1) begin
      m_deb = 1'b1;
    end
    m_led = lnext;
    if (press_now) begin
      m_mode = (m_mode + 1) % 4;
      m_j = 0;
    end else begin
      m_j++;
    end
    m_g++;
    @(posedge clk);
    #1;
    chk("model_led", led, m_led);
    chk("model_mode", mode, m_mode);
    chk("model_tick", tick, (m_j % 4) == 3);
  endtask

  task automatic hold(input logic v, input int n);
    btn_n = v;
    for (int i = 0; i < n; i++) step();
  endtask

  // Async reset: outputs must clear without a clock edge; release 1 ns after an edge.
  task automatic apply_reset(input int low_cycles);
    rstn = 1'b0;
    #1;
    chk("rst_async_led", led, 0);
    chk("rst_async_mode", mode, 0);
    chk("rst_async_tick", tick, 0);
    for (int i = 0; i < low_cycles; i++) @(posedge clk);
    #1;
    chk("rst_hold_led", led, 0);
    chk("rst_hold_mode", mode, 0);
    btn_n = 1'b1;
    rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       btn_n;
    logic [2:0] led;
    logic [1:0] mode;
    logic       tick;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int guard, kind, prev_mode;
    vecs[0]  = '{1'b1, 3'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 3'd0, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 3'd0, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 2'd0, 1'b1};
    vecs[7]  = '{1'b1, 3'd1, 2'd0, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 3'd2, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 2'd0, 1'b1};
    vecs[11] = '{1'b1, 3'd2, 2'd0, 1'b0};

    rstn = 1'b0;
    btn_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset(2);

    // Idle COUNT from reset: table, then wrap 7 -> 0.
    for (int i = 0; i < 12; i++) begin
      btn_n = vecs[i].btn_n;
      step();
      chk("vec_led", led, vecs[i].led);
      chk("vec_mode", mode, vecs[i].mode);
      chk("vec_tick", tick, vecs[i].tick);
    end
    hold(1'b1, 20);
    chk("count_top", led, 7);
    step();
    chk("count_wrap", led, 0);

    // Clean press then long hold: exactly one mode step.
    hold(1'b0, 20);
    chk("press_mode", mode, 1);
    hold(1'b0, 100);
    chk("held_mode", mode, 1);
    hold(1'b1, 20);

    // Bounce shorter than the debounce window is ignored.
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 15);
    chk("bounce_mode", mode, 1);
    hold(1'b0, 12);
    chk("post_bounce_mode", mode, 2);
    hold(1'b1, 15);

    // Line up the press edge with a tick edge: press must win.
    guard = 0;
    while ((m_j % 4) != 1 && guard < 16) begin
      step();
      guard++;
    end
    chk("align_wait", guard < 16, 1);
    hold(1'b0, 10);
    chk("tick_at_press", tick, 1);
    step();
    chk("press_tick_mode", mode, 3);
    chk("press_tick_cleared", tick, 0);
    hold(1'b0, 2);
    chk("tick_gap0", tick, 0);
    step();
    chk("tick_gap1", tick, 1);

    // Full breathe triangle (30 ticks) and a bit more.
    hold(1'b1, 130);

    // Reset mid-ramp at duty 128 with a press in progress.
    guard = 0;
    while ((m_j % 120) != 29 && guard < 130) begin
      step();
      guard++;
    end
    chk("duty_wait", guard < 130, 1);
    hold(1'b0, 5);
    apply_reset(3);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("tick_after_rst", tick, i == 3);
    end
    hold(1'b1, 30);
    chk("press_discarded", mode, 0);

    // Four clean presses cycle through all modes.
    for (int p = 1; p <= 4; p++) begin
      hold(1'b0, 12);
      chk("cycle_mode", mode, p % 4);
      hold(1'b1, 24);
    end

    // Randomised button activity with occasional resets.
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 19);
      prev_mode = m_mode;
      if (kind == 0) begin
        apply_reset($urandom_range(1, 3));
      end else if (kind < 7) begin
        hold(1'b0, $urandom_range(1, 7));
      end else if (kind < 12) begin
        hold(1'b0, $urandom_range(9, 30));
      end else begin
        hold(1'b1, $urandom_range(1, 20));
      end
      if (prev_mode < 0) chk("never", 0, 1);
    end
    hold(1'b1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
